// File: rtl/receiver_ash.sv
// Serial UART receiver: start, 8 data bits LSB first, even parity, stop.
// Reassembles each frame into a valid/ready holding register with parity, framing and overrun flags.
module receiver_ash #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_index, bit_index_n;
    logic [7:0]    shift, shift_n;
    logic          par_s, par_s_n;
    logic          done;
    logic          pe;
    logic          fe;
    logic          sample;
    logic          pop;

    assign sample = (cnt == CNT_LAST);
    assign pop    = rx_valid && rx_ready;
    assign busy   = (state != IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_n     = state;
        cnt_n       = cnt;
        bit_index_n = bit_index;
        shift_n     = shift;
        par_s_n     = par_s;
        done        = 1'b0;
        pe          = (par_s != ^shift);
        fe          = ~RXD;

        case (state)
            IDLE: begin
                if (!RXD) begin
                    if (HALF == 0) begin
                        state_n     = DATA;
                        cnt_n       = '0;
                        bit_index_n = 3'd0;
                    end else begin
                        state_n = START;
                        cnt_n   = CW'(1);
                    end
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    if (!RXD) begin
                        state_n     = DATA;
                        cnt_n       = '0;
                        bit_index_n = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (sample) begin
                    shift_n[bit_index] = RXD;
                    cnt_n              = '0;
                    if (bit_index == 3'd7) state_n = PARITY;
                    else                   bit_index_n = bit_index + 3'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PARITY: begin
                if (sample) begin
                    par_s_n = RXD;
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (sample) begin
                    done    = 1'b1;
                    cnt_n   = '0;
                    // A low stop bit must not be mistaken for the next start bit.
                    state_n = RXD ? IDLE : WAIT_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (RXD) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_index <= 3'd0;
            shift     <= 8'h00;
            par_s     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_index <= bit_index_n;
            shift     <= shift_n;
            par_s     <= par_s_n;
        end
    end

    // A completing frame wins over a pop: a same-edge pop frees the slot for the new byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!rx_valid || rx_ready) begin
                rx_data    <= shift;
                parity_err <= pe;
                frame_err  <= fe;
                overrun    <= 1'b0;
                rx_valid   <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (pop) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: doc/receiver_ash.md
# receiver_ash

- Serial UART receiver; the downstream partner of the team's transmitter.
- Frame format, LSB first: one start bit (0), 8 data bits, even-parity bit, one stop bit (1).
- Reassembles the frame into a byte and flags parity, framing and overrun errors.
- Presents the byte on a valid/ready holding register to the consuming logic.
- Bit period is parameterised. CLKS_PER_BIT=1 matches the transmitter's one-bit-per-clock output on the same clock, for direct loopback.

## Interface
- CLKS_PER_BIT, default 1: clocks per serial bit. Legal range ≥1. HALF = (CLKS_PER_BIT-1)/2 (integer division) is the mid-bit sample offset.
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset), one clock domain.
- RXD  input  1  serial line; idles high; already synchronous to clk.
- rx_data  output  8  received byte; reset 0x00.
- rx_valid  output  1  holding register full; reset 0.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready at an edge.
- parity_err  output  1  held-byte parity mismatch; reset 0.
- frame_err  output  1  held byte had stop bit sampled 0; reset 0.
- overrun  output  1  one or more later frames were dropped while the byte was held; reset 0.
- busy  output  1  1 whenever state ≠ IDLE; reset 0.

## Operation

States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Internal registers:
- cnt: bit-period counter, wide enough for CLKS_PER_BIT-1.
- bit_index[2:0].
- shift[7:0].
- par_s.

State transitions:
- **IDLE:** RXD=0 sampled at an edge (edge E0) starts a frame.
  - HALF==0: go to DATA with cnt=0, bit_index=0.
  - Otherwise: go to START with cnt=1.
- **START:** cnt increments until cnt==HALF. At that edge:
  - RXD=0: go to DATA, cnt=0, bit_index=0.
  - RXD=1: false start; return to IDLE with no output and no flags.
- **DATA:** cnt counts 0..CLKS_PER_BIT-1. At cnt==CLKS_PER_BIT-1:
  - Sample RXD into shift[bit_index] and set cnt=0.
  - After bit_index==7 go to PARITY; otherwise bit_index+1.
- **PARITY:** same counting; at the sample edge latch par_s and go to STOP.
- **STOP:** same counting; at the sample edge complete the frame:
  - pe = par_s ≠ ^shift (even parity: the parity bit equals the XOR of the data bits).
  - fe = (RXD==0).
  - fe=0: go to IDLE.
  - fe=1: go to WAIT_IDLE, so a low line is not re-detected as a start bit.
- **WAIT_IDLE:** leave for IDLE on the first edge with RXD=1.

Frame completion at the STOP sample edge:
- Holding register free, or being popped this same edge (rx_valid && rx_ready): load rx_data=shift, parity_err=pe, frame_err=fe, overrun=0, rx_valid=1.
- Holding register full and not popped: drop the frame. rx_data, parity_err and frame_err are unchanged; overrun is set to 1.

Other holding-register rules:
- A pop (rx_valid && rx_ready) without a simultaneous completion clears rx_valid and overrun. rx_data is retained.
- rx_ready is ignored while rx_valid=0.
- reset=0 at any time, including mid-frame, immediately forces IDLE. All outputs and internal registers go to 0; any partial frame is discarded.
- States outside the defined set recover to IDLE on the next edge.

## Timing
- Sample points, relative to E0:
  - Start bit: E0+HALF.
  - Data bit i: E0+HALF+(i+1)·CLKS_PER_BIT.
  - Parity: E0+HALF+9·CLKS_PER_BIT.
  - Stop: E0+HALF+10·CLKS_PER_BIT.
- rx_valid and the flags are registered; they are visible after the stop-sample edge.
- CLKS_PER_BIT=1:
  - Data sampled at E0+1..E0+8, parity at E0+9, stop at E0+10.
  - rx_valid high from E0+10.
  - The next start bit can be detected at E0+11, so back-to-back frames with a single idle bit are received without loss.
- busy goes high at E0 and returns low at the stop-sample edge (fe=0) or when WAIT_IDLE exits.

## Test plan
1. Transmitter loopback, CLKS_PER_BIT=1, send 0xA5 (parity 0) → rx_data=0xA5, rx_valid=1 at E0+10, all flags 0; pop with rx_ready=1 → rx_valid=0 next edge.
2. CLKS_PER_BIT=16, drive the frame for 0x3C with the parity bit flipped to 1 → rx_data=0x3C, parity_err=1, frame_err=0, rx_valid at E0+167.
3. CLKS_PER_BIT=16, RXD low for 3 clocks, then high → false start; state returns to IDLE at E0+7, rx_valid stays 0.
4. Frame 0x81 with the stop bit held 0 for 20 bit times → frame_err=1, busy stays 1 until RXD returns high; no spurious second frame.
5. rx_ready=0, send 0x11 then 0x22 → rx_data=0x11, overrun=1. Repeat with a pop on the exact completion edge of 0x22 → rx_data=0x22, overrun=0.
6. Assert reset (low) at the 4th data bit of a frame, release, then send 0x5A → all outputs 0 during reset; only 0x5A is received, correct.
